traffic_controller_fsm: RTL and testbench
=========================================

Name: traffic_controller_fsm

Overview:
- Moore-style controller for a main-street/side-street intersection with a pedestrian walk phase.
- Sequences the main-street lights (Gm/Ym/Rm), the side-street lights (Gs/Ys/Rs) and the walk lamp (W).
- Each phase's duration comes from an external timer: this block issues start_timer plus requesting_interval, and waits for expired.
- Sits between the walk-request register, the traffic sensor and the parameter/timer block.

Parameters:
- INT_BASE, 2'b00, interval code for tBASE.
- INT_EXT, 2'b01, interval code for tEXT.
- INT_YEL, 2'b10, interval code for tYEL. Code 2'b11 is never issued.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (one clock domain; active-low async reset).
- traffic_sensor  in  1  side-street car present (synchronous, level).
- wr_to_fsm  in  1  latched walk request from external walk register (level).
- reprogram  in  1  synchronous restart after timing parameters change.
- expired  in  1  one-cycle pulse from timer: requested interval elapsed.
- wr_reset  out  1  one-cycle pulse clearing the external walk register.
- requesting_interval  out  2  interval code for the current state.
- start_timer  out  1  one-cycle pulse: (re)start timer with requesting_interval.
- Gm, Ym, Rm  out  1 each  main-street green/yellow/red.
- W  out  1  walk lamp.
- Gs, Ys, Rs  out  1 each  side-street green/yellow/red.

Behaviour:
- Outputs registered: lights and requesting_interval decode the state register; start_timer and wr_reset are registered pulses.
- States, with lights on and interval code:
  - MG1: Gm, Rs; BASE.
  - MG2: Gm, Rs; BASE.
  - MY: Ym, Rs; YEL.
  - WALK: Rm, Rs, W; EXT.
  - SG1: Rm, Gs; BASE.
  - SG2: Rm, Gs; EXT.
  - SY: Rm, Ys; YEL.
- Exactly one main light and one side light are on in every state; W is on only in WALK.
- Transitions are taken on a clock edge with expired=1, except in a cycle where start_timer=1 (expired is ignored that cycle):
  - MG1->MG2; MG2->MY.
  - MY->WALK if wr_to_fsm=1, else MY->SG1.
  - WALK->SG1.
  - SG1->SG2 if traffic_sensor=1, else SG1->SY.
  - SG2->SY; SY->MG1.
- traffic_sensor and wr_to_fsm are sampled only on the transition edge.
- On every state entry, start_timer=1 for exactly the first cycle in the new state. requesting_interval is already valid in that cycle and is held for the whole state.
- On entry to WALK, wr_reset=1 for the same single cycle as start_timer.
- reprogram=1 (synchronous) forces MG1 with a start_timer pulse next cycle. It has priority over expired and all other inputs. Held high, it keeps restarting MG1 with start_timer=1 every cycle.
- reset=0 (async), taking effect immediately:
  - State becomes MG1: Gm=1, Rs=1, all other lights 0, W=0.
  - requesting_interval=00, wr_reset=0, start_timer=1.
  - start_timer stays 1 while reset is low and clears after the first rising edge following release.
  - Reset mid-phase abandons the phase with no yellow.
- Staying in a state without expired: no output change, no pulses.
- expired pulses arriving in a state where none is expected after a transition are simply the next transition trigger. There is no queuing, and at most one transition per cycle.

Decomposition:
- Shared package traffic_pkg:
  - state enum (MG1, MG2, MY, WALK, SG1, SG2, SY);
  - interval codes INT_BASE/INT_EXT/INT_YEL.
- The timer and parameter blocks reuse these codes.
- No sub-module: a single module with a next-state process, a registered state/pulse process, and a light-decode process.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> Gm=1, Rs=1, others 0, requesting_interval=00, start_timer=1. After release, start_timer=0 from the second cycle.
- Main cycle, no requests: pulse expired ×2 -> MG2 then MY (Ym=1, interval=10, start_timer pulse each entry). Next expired with wr_to_fsm=0 -> SG1 (Gs=1, Rm=1, interval=00).
- Side extension: in SG1 with traffic_sensor=1, pulse expired -> SG2 (interval=01). Next expired -> SY (Ys=1, interval=10). Next expired -> MG1. Repeat with traffic_sensor=0 -> SG1 goes directly to SY.
- Walk: wr_to_fsm=1 when MY expires -> WALK, with W=1, Rm=Rs=1, interval=01, and wr_reset=start_timer=1 for exactly one cycle. Next expired -> SG1 with W=0.
- Priority: in SG2, assert reprogram and expired in the same cycle -> next state MG1 (Gm=1, start_timer=1), not SY.
- Async reset mid-phase: in WALK, drop reset between clock edges -> outputs go to MG1 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding and timer interval codes
// for the intersection controller, timer and parameter blocks.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG1  = 3'd4,
    SG2  = 3'd5,
    SY   = 3'd6
  } state_e;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

endpackage

// File: rtl/traffic_controller_fsm.sv
// Moore intersection controller: main/side lights, walk lamp, timer requests.
// In: clk, reset(async low), traffic_sensor, wr_to_fsm, reprogram, expired.
// Out: wr_reset, requesting_interval, start_timer, Gm/Ym/Rm, W, Gs/Ys/Rs.
module traffic_controller_fsm
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       traffic_sensor,
  input  logic       wr_to_fsm,
  input  logic       reprogram,
  input  logic       expired,
  output logic       wr_reset,
  output logic [1:0] requesting_interval,
  output logic       start_timer,
  output logic       Gm,
  output logic       Ym,
  output logic       Rm,
  output logic       W,
  output logic       Gs,
  output logic       Ys,
  output logic       Rs
);

  state_e state_q, state_d;
  logic   start_q, start_d;
  logic   wr_rst_q, wr_rst_d;

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    wr_rst_d = 1'b0;
    if (reprogram) begin
      state_d = MG1;
      start_d = 1'b1;
    end else if (!start_q && expired) begin
      // expired is ignored in the cycle the timer is being restarted
      unique case (state_q)
        MG1:     state_d = MG2;
        MG2:     state_d = MY;
        MY:      state_d = wr_to_fsm ? WALK : SG1;
        WALK:    state_d = SG1;
        SG1:     state_d = traffic_sensor ? SG2 : SY;
        SG2:     state_d = SY;
        SY:      state_d = MG1;
        default: state_d = MG1;
      endcase
      start_d  = 1'b1;
      wr_rst_d = (state_d == WALK);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MG1;
      start_q  <= 1'b1;
      wr_rst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      wr_rst_q <= wr_rst_d;
    end
  end

  assign start_timer = start_q;
  assign wr_reset    = wr_rst_q;

  always_comb begin
    {Gm, Ym, Rm, W, Gs, Ys, Rs} = 7'b0000000;
    requesting_interval = INT_BASE;
    unique case (state_q)
      MG1, MG2: begin
        {Gm, Rs} = 2'b11;
        requesting_interval = INT_BASE;
      end
      MY: begin
        {Ym, Rs} = 2'b11;
        requesting_interval = INT_YEL;
      end
      WALK: begin
        {Rm, Rs, W} = 3'b111;
        requesting_interval = INT_EXT;
      end
      SG1: begin
        {Rm, Gs} = 2'b11;
        requesting_interval = INT_BASE;
      end
      SG2: begin
        {Rm, Gs} = 2'b11;
        requesting_interval = INT_EXT;
      end
      SY: begin
        {Rm, Ys} = 2'b11;
        requesting_interval = INT_YEL;
      end
      default: begin
        {Gm, Rs} = 2'b11;
        requesting_interval = INT_BASE;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_controller_fsm.sv
// Directed plus randomized bench for traffic_controller_fsm
// against a phase-name reference model.
module tb_traffic_controller_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       traffic_sensor = 1'b0;
  logic       wr_to_fsm = 1'b0;
  logic       reprogram = 1'b0;
  logic       expired = 1'b0;
  logic       wr_reset;
  logic [1:0] requesting_interval;
  logic       start_timer;
  logic       Gm, Ym, Rm, W, Gs, Ys, Rs;

  int vectors = 0;
  int miscompares = 0;

  string m_ph = "MG1";
  bit    m_fresh = 1'b1;
  bit    m_wrp = 1'b0;

  traffic_controller_fsm dut (
    .clk                 (clk),
    .reset               (reset),
    .traffic_sensor      (traffic_sensor),
    .wr_to_fsm           (wr_to_fsm),
    .reprogram           (reprogram),
    .expired             (expired),
    .wr_reset            (wr_reset),
    .requesting_interval (requesting_interval),
    .start_timer         (start_timer),
    .Gm                  (Gm),
    .Ym                  (Ym),
    .Rm                  (Rm),
    .W                   (W),
    .Gs                  (Gs),
    .Ys                  (Ys),
    .Rs                  (Rs)
  );

  always #5 clk = ~clk;

  // lights {Gm,Ym,Rm,W,Gs,Ys,Rs} and interval for a phase
  function automatic logic [8:0] phase_out(input string p);
    if (p == "MG1" || p == "MG2") return {7'b1000001, 2'b00};
    if (p == "MY")   return {7'b0100001, 2'b10};
    if (p == "WALK") return {7'b0011001, 2'b01};
    if (p == "SG1")  return {7'b0010100, 2'b00};
    if (p == "SG2")  return {7'b0010100, 2'b01};
    return {7'b0010010, 2'b10};
  endfunction

  function automatic string succ(input string p, input bit ts, input bit wr);
    if (p == "MG1") return "MG2";
    if (p == "MG2") return "MY";
    if (p == "MY")  return wr ? "WALK" : "SG1";
    if (p == "WALK") return "SG1";
    if (p == "SG1") return ts ? "SG2" : "SY";
    if (p == "SG2") return "SY";
    return "MG1";
  endfunction

  task automatic model_reset();
    m_ph = "MG1";
    m_fresh = 1'b1;
    m_wrp = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (reprogram) begin
      m_ph = "MG1";
      m_fresh = 1'b1;
      m_wrp = 1'b0;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
      m_wrp = 1'b0;
    end else if (expired) begin
      m_ph = succ(m_ph, traffic_sensor, wr_to_fsm);
      m_fresh = 1'b1;
      m_wrp = (m_ph == "WALK");
    end else begin
      m_wrp = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    logic [10:0] obs, exp_v;
    obs = {Gm, Ym, Rm, W, Gs, Ys, Rs,
           requesting_interval, start_timer, wr_reset};
    exp_v = {phase_out(m_ph), m_fresh, m_wrp};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s phase=%s obs=%b exp=%b", tag, m_ph, obs, exp_v);
    end
  endtask

  task automatic step(input bit e, input bit ts, input bit wr,
                      input bit rp, input string tag);
    expired = e;
    traffic_sensor = ts;
    wr_to_fsm = wr;
    reprogram = rp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 model_reset();
    check("reset_async");
    repeat (3) begin
      @(negedge clk);
      check("reset_hold");
    end
    reset = 1'b1;
    #1 check("reset_release");

    step(0, 0, 0, 0, "mg1_settle");
    step(1, 0, 0, 0, "to_mg2");
    step(0, 0, 0, 0, "mg2_hold");
    step(1, 0, 0, 0, "to_my");
    step(1, 0, 0, 0, "exp_ignored");
    step(1, 0, 0, 0, "to_sg1");
    step(0, 1, 0, 0, "sg1_hold");
    step(1, 1, 0, 0, "to_sg2");
    step(0, 0, 0, 0, "sg2_settle");
    step(1, 0, 0, 0, "to_sy");
    step(0, 0, 0, 0, "sy_settle");
    step(1, 0, 0, 0, "to_mg1");
    step(0, 0, 0, 0, "mg1_settle2");
    step(1, 0, 0, 0, "to_mg2b");
    step(0, 0, 0, 0, "mg2b");
    step(1, 0, 0, 0, "to_myb");
    step(0, 0, 0, 0, "myb");
    step(1, 0, 0, 0, "to_sg1b");
    step(0, 0, 0, 0, "sg1b");
    step(1, 0, 0, 0, "sg1_to_sy");
    step(0, 0, 0, 0, "sy_b");
    step(1, 0, 0, 0, "to_mg1b");
    step(0, 0, 0, 0, "mg1c");
    step(1, 0, 0, 0, "to_mg2c");
    step(0, 0, 0, 0, "mg2c");
    step(1, 0, 0, 0, "to_myc");
    step(0, 0, 1, 0, "myc");
    step(1, 0, 1, 0, "to_walk");
    step(0, 0, 0, 0, "walk_hold");
    step(1, 0, 0, 0, "walk_to_sg1");
    step(0, 1, 0, 0, "sg1c");
    step(1, 1, 0, 0, "to_sg2b");
    step(0, 0, 0, 0, "sg2b");
    step(1, 0, 0, 1, "reprog_prio");
    step(0, 0, 0, 1, "reprog_held");
    step(0, 0, 0, 0, "reprog_drop");

    // reach WALK again, then async reset between edges
    step(1, 0, 0, 0, "w_mg2");
    step(0, 0, 0, 0, "w_mg2s");
    step(1, 0, 0, 0, "w_my");
    step(0, 0, 1, 0, "w_mys");
    step(1, 0, 1, 0, "w_walk");
    step(0, 0, 0, 0, "w_walks");
    #2 reset = 1'b0;
    #1 model_reset();
    check("reset_midwalk");
    @(negedge clk);
    check("reset_midwalk_hold");
    reset = 1'b1;
    #1 check("reset_midwalk_rel");

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(2, 0) == 0,
           $urandom_range(1, 0) == 1,
           $urandom_range(1, 0) == 1,
           $urandom_range(39, 0) == 0,
           "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
